// File: rtl/div_ctrl.sv
// div_ctrl: issue/sequencing controller for the shared multi-cycle divider.
// Sign fix-up, special-case resolution and a one-entry DIV/REM result cache.
module div_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic [4:0]      rsp_rd_o,
    output logic            busy_o,
    output logic            div_req_o,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    output logic            div_is_q_o,
    input  logic [2*XLEN:0] div_result_i,
    input  logic            div_ready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        RESP  = 2'b10,
        DRAIN = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic            rdy_q, busy_q, rsp_vld_q, div_req_q;
    logic [XLEN-1:0] rsp_data_q, div_a_q, div_b_q;
    logic [4:0]      rsp_rd_q;
    logic            is_q_q, sgn_q, neg_q_q, neg_r_q;
    logic [XLEN-1:0] rs1_q, rs2_q;

    logic            c_vld_q, c_sgn_q;
    logic [XLEN-1:0] c_rs1_q, c_rs2_q, c_q_q, c_r_q;

    logic            is_sgn, is_q, rs1_neg, rs2_neg;
    logic            is_div0, is_ovf, hit, fast, accept;
    logic            acc_fast, acc_run, done;
    logic [XLEN-1:0] min_val, abs1, abs2, fast_data;
    logic [XLEN-1:0] q_raw, r_raw, q_fix, r_fix;
    logic            unused_mid;

    assign min_val = {1'b1, {(XLEN-1){1'b0}}};
    assign is_sgn  = ~op_i[0];
    assign is_q    = ~op_i[1];
    assign rs1_neg = is_sgn & rs1_i[XLEN-1];
    assign rs2_neg = is_sgn & rs2_i[XLEN-1];
    assign abs1    = rs1_neg ? -rs1_i : rs1_i;
    assign abs2    = rs2_neg ? -rs2_i : rs2_i;

    assign is_div0 = (rs2_i == '0);
    assign is_ovf  = is_sgn & (rs1_i == min_val) & (rs2_i == '1);
    assign hit     = c_vld_q & (c_rs1_q == rs1_i) &
                     (c_rs2_q == rs2_i) & (c_sgn_q == is_sgn);
    assign fast    = is_div0 | is_ovf | hit;
    assign accept  = req_valid_i & ~flush_i;

    // cache never holds b==0 or the signed overflow pair, so these are exclusive
    always_comb begin
        fast_data = '0;
        unique case (1'b1)
            is_div0: fast_data = is_q ? '1 : rs1_i;
            is_ovf:  fast_data = is_q ? min_val : '0;
            hit:     fast_data = is_q ? c_q_q : c_r_q;
            default: fast_data = '0;
        endcase
    end

    assign q_raw      = div_result_i[XLEN-1:0];
    assign r_raw      = div_result_i[2*XLEN:XLEN+1];
    assign unused_mid = div_result_i[XLEN];
    assign q_fix      = neg_q_q ? -q_raw : q_raw;
    assign r_fix      = neg_r_q ? -r_raw : r_raw;

    always_comb begin
        state_d  = state_q;
        acc_fast = 1'b0;
        acc_run  = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (fast) begin
                        state_d  = RESP;
                        acc_fast = 1'b1;
                    end else begin
                        state_d = RUN;
                        acc_run = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (div_ready_i) begin
                    state_d = RESP;
                    done    = 1'b1;
                end
            end
            RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // handshake outputs come straight from flops so reset is glitch-free
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rdy_q     <= 1'b1;
            busy_q    <= 1'b0;
            rsp_vld_q <= 1'b0;
            div_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
            rsp_vld_q <= (state_d == RESP);
            div_req_q <= (state_d == RUN);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            is_q_q     <= 1'b0;
            sgn_q      <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            if (acc_fast || acc_run) begin
                rsp_rd_q <= rd_i;
            end
            if (acc_fast) begin
                rsp_data_q <= fast_data;
            end
            if (acc_run) begin
                div_a_q <= abs1;
                div_b_q <= abs2;
                is_q_q  <= is_q;
                sgn_q   <= is_sgn;
                neg_q_q <= rs1_neg ^ rs2_neg;
                neg_r_q <= rs1_neg;
                rs1_q   <= rs1_i;
                rs2_q   <= rs2_i;
            end
            if (done) begin
                rsp_data_q <= is_q_q ? q_fix : r_fix;
            end
        end
    end

    // entry holds sign-corrected results so either half answers a hit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_vld_q <= 1'b0;
            c_sgn_q <= 1'b0;
            c_rs1_q <= '0;
            c_rs2_q <= '0;
            c_q_q   <= '0;
            c_r_q   <= '0;
        end else if (done) begin
            c_vld_q <= 1'b1;
            c_sgn_q <= sgn_q;
            c_rs1_q <= rs1_q;
            c_rs2_q <= rs2_q;
            c_q_q   <= q_fix;
            c_r_q   <= r_fix;
        end
    end

    assign req_ready_o = rdy_q;
    assign busy_o      = busy_q;
    assign rsp_valid_o = rsp_vld_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_rd_o    = rsp_rd_q;
    assign div_req_o   = div_req_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
    assign div_is_q_o  = is_q_q;

endmodule
